// File: rtl/seg_scan_display_if.sv
// rtl/seg_scan_display_if.sv - display driver bus: time word, mode inputs, segment/anode outputs
interface seg_scan_display_if;
  logic [31:0] data;
  logic        ADJMODE;
  logic        SELMODE;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (
    output data,
    output ADJMODE,
    output SELMODE,
    input  an,
    input  seg,
    input  dp
  );

  modport slave (
    input  data,
    input  ADJMODE,
    input  SELMODE,
    output an,
    output seg,
    output dp
  );
endinterface

// File: rtl/seg_scan_display.sv
// rtl/seg_scan_display.sv - 8-digit multiplexed seven-segment scanner with frame snapshot; SEG_BLINK_EN adds adjust-field blink
module seg_scan_display #(
  parameter int SCAN_DIV     = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic              CP,
  input  logic              RST,
  seg_scan_display_if.slave bus
);
  localparam int            CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [31:0]   snap;
  logic          started;

  logic          slot_end;
  logic          frame_end;
  logic [2:0]    idx_nx;
  logic [31:0]   snap_nx;
  logic [3:0]    nib_nx;
  logic          blank_nx;

  // Active-low a..g patterns; A-F rendered as A, b, C, d, E, F.
  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
  endfunction

  // Digit about to be shown; the first edge after reset loads digit 0 straight from data.
  always_comb begin
    slot_end  = started && (cnt == CNT_LAST);
    frame_end = slot_end && (idx == 3'd7);
    idx_nx    = started ? idx + 3'd1 : 3'd0;
    snap_nx   = (!started || frame_end) ? bus.data : snap;
    nib_nx    = snap_nx[{idx_nx, 2'b00} +: 4];
  end

`ifdef SEG_BLINK_EN
  localparam int            BW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [BW-1:0] blink_cnt;
  logic          phase;
  logic          phase_nx;
  logic          field_sel;

  // Suppress the adjusted field using the phase that the upcoming slot will see.
  always_comb begin
    phase_nx  = (frame_end && (blink_cnt == BLINK_LAST)) ? ~phase : phase;
    field_sel = bus.SELMODE ? idx_nx[2] : (idx_nx[2:1] == 2'b01);
    blank_nx  = bus.ADJMODE && phase_nx && field_sel;
  end

  // Count frames and flip the blink phase every BLINK_FRAMES frames, independent of ADJMODE.
  always_ff @(posedge CP or posedge RST) begin
    if (RST) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (frame_end) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end
`else
  localparam int unused_blink_frames = BLINK_FRAMES;
  logic          unused_mode;

  assign unused_mode = bus.ADJMODE ^ bus.SELMODE;
  assign blank_nx    = 1'b0;
`endif

  // Prescaler, digit index, frame snapshot and the registered pin drive.
  always_ff @(posedge CP or posedge RST) begin
    if (RST) begin
      cnt     <= '0;
      idx     <= 3'd0;
      snap    <= 32'h0;
      started <= 1'b0;
      bus.an  <= 8'hFF;
      bus.seg <= 7'h7F;
      bus.dp  <= 1'b1;
    end else if (!started || slot_end) begin
      started <= 1'b1;
      cnt     <= '0;
      idx     <= idx_nx;
      snap    <= snap_nx;
      bus.an  <= blank_nx ? 8'hFF : ~(8'h01 << idx_nx);
      bus.seg <= blank_nx ? 7'h7F : glyph(nib_nx);
      bus.dp  <= blank_nx || !((idx_nx == 3'd2) || (idx_nx == 3'd4));
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: doc/seg_scan_display.md
# seg_scan_display

Time-multiplexed 8-digit seven-segment display driver for the digital clock. It reads the clock core's 32-bit packed BCD time word (seconds, minutes, hours nibbles) and scans it onto a common-anode display, one digit per slot. It takes a frame-coherent snapshot of the time word and blinks the field currently being adjusted. It sits between the clock core's `data` bus and the board's segment/anode pins.

## Interface
- `SCAN_DIV`, 100000: CP cycles per digit slot; legal range ≥ 2.
- `BLINK_FRAMES`, 64: frames per blink half-period; legal range ≥ 1.

- `CP` input 1: system clock; all state updates on rising edge.
- `RST` input 1: asynchronous, active-high reset.
- `data` input 32: packed time word; nibble k = `data[4k+3:4k]` is shown on digit k. Digits 1:0 are seconds, 3:2 minutes, 7:4 hours field.
- `ADJMODE` input 1: 1 = adjust mode; the selected field blinks.
- `SELMODE` input 1: field select in adjust mode; 0 = minutes (digits 3:2), 1 = hours (digits 7:4).
- `an` output 8: digit enables, active-low; `an[k]` drives digit k.
- `seg` output 7: segments a..g, active-low; `seg[0]`=a … `seg[6]`=g.
- `dp` output 1: decimal point, active-low.

## Operation
- Prescaler `cnt` counts 0..SCAN_DIV-1 and wraps. The edge where `cnt` wraps advances digit index `idx` 0..7, wrapping 7→0.
- Frame = 8 slots. Snapshot register `snap[31:0]` captures `data` on the edge where `idx` wraps 7→0, and on the first edge after `RST` deasserts. Mid-frame changes on `data` are not displayed until the next frame.
- Slot k: `an` = all ones except `an[k]`=0. `seg` = hex glyph of `snap` nibble k. Glyphs are 0–9 standard and A–F as A, b, C, d, E, F.
- `dp`=0 on digits 2 and 4 (field separators); 1 elsewhere.
- Blink (see Configuration): `blink_cnt` counts frames 0..BLINK_FRAMES-1; `phase` toggles at its wrap.
- When `ADJMODE`=1 and `phase`=1, digits of the selected field are suppressed: `an[k]`=1 and `seg`=7'h7F for those slots. `dp` is also forced to 1 in those slots.
- `ADJMODE` and `SELMODE` are sampled every cycle, with no snapshot. A change takes effect at the next slot output update.
- Leaving adjust mode during `phase`=1 shows the field from the next slot. `blink_cnt` and `phase` keep running regardless of `ADJMODE`.

## Timing
- Reset values: `an`=8'hFF, `seg`=7'h7F, `dp`=1. Internal state: `cnt`=0, `idx`=0, `snap`=0, `blink_cnt`=0, `phase`=0 (visible).
- All outputs are registered and update only on the edge where `idx` changes. The one exception is the first edge after reset release, which loads digit 0 from the `data` sampled at that same edge.
- Each digit is driven for exactly SCAN_DIV cycles. A frame lasts 8·SCAN_DIV cycles, and a blink half-period lasts 8·SCAN_DIV·BLINK_FRAMES cycles.
- `phase` toggles on the same edge as the 7→0 wrap that ends the frame with `blink_cnt`=BLINK_FRAMES-1. The new phase applies to digit 0 of the new frame.
- Exactly one `an` bit is low at any time, or none when reset is active or the digit is blink-suppressed.
- `RST` asserted mid-slot forces the reset values immediately (asynchronously); the scan then restarts at digit 0.

## Configuration
- `SEG_BLINK_EN` defined: blink counter, phase and suppression logic are compiled in, as described above.
- `SEG_BLINK_EN` undefined: no blink state is built. `ADJMODE`/`SELMODE` are ignored (left unconnected internally), `BLINK_FRAMES` has no effect, and all digits always display.

## Test plan
Bench parameters: SCAN_DIV=4, BLINK_FRAMES=2.
- Reset then release with `data`=32'h0012_3456 -> `an`=8'hFE, `seg`=glyph 6 (7'h02), `dp`=1. After 4 cycles, `an`=8'hFD with glyph 5 (7'h12). Digit 2 shows `dp`=0.
- Hold `data` static and run 3 frames -> `an` cycles FE,FD,FB,F7,EF,DF,BF,7F, each exactly 4 cycles. Segment values match nibble glyphs, with A–F correct for `data`=32'hFEDC_BA98.
- Change `data` from 32'h0000_0000 to 32'h1111_1111 while `idx`=3 -> digits 3..7 still show 0 this frame; all digits show 1 from the next frame.
- `ADJMODE`=1, `SELMODE`=0 -> in frames 2–3 of every 4 (`phase`=1), digits 2,3 have `an` bit high and `seg`=7'h7F; other digits are unchanged. With `SELMODE`=1, digits 4–7 are suppressed instead.
- Assert `RST` mid-slot at digit 5 -> `an`=8'hFF and `seg`=7'h7F in the same cycle. After release, the scan restarts at digit 0 with `phase`=0.
- Build without `SEG_BLINK_EN` and `ADJMODE`=1 -> no digit is ever suppressed over 8 frames.
